// File: rtl/sevenseg_scan_pkg.sv
// Shared display constants: BCD digit width, default digit count and
// active-low seven-segment patterns (bit 0 = a .. bit 6 = g).
package sevenseg_scan_pkg;

  localparam int unsigned BCD_W              = 4;
  localparam int unsigned NUM_DIGITS_DEFAULT = 4;

  typedef logic [BCD_W-1:0] bcd_t;
  typedef logic [6:0]       seg_t;

  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_DASH  = 7'h3F;
  localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/sevenseg_scan_if.sv
// Digit feed from the counters and the multiplexed display drive.
interface sevenseg_scan_if
  import sevenseg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEFAULT
);

  logic [BCD_W*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]       dp_in;
  logic                        enable;
  logic [NUM_DIGITS-1:0]       an;
  seg_t                        seg;
  logic                        dp;
  logic                        frame_start;

  modport master (
    output digits_in, dp_in, enable,
    input  an, seg, dp, frame_start
  );

  modport slave (
    input  digits_in, dp_in, enable,
    output an, seg, dp, frame_start
  );

endinterface

// File: rtl/sevenseg_scan_bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder; A-F show a dash.
module bcd_to_7seg
  import sevenseg_scan_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg
);

  // Pattern lookup for the selected digit.
  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed common-anode display driver with frame-synchronous
// shadow digits, per-slot dead time and leading-zero blanking.
module sevenseg_scan
  import sevenseg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = NUM_DIGITS_DEFAULT,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEAD_CYCLES = 16,
  parameter int unsigned LZ_BLANK    = 1
) (
  input logic            clk,
  input logic            rst,
  sevenseg_scan_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(REFRESH_DIV);
  localparam int unsigned SLOT_W = $clog2(NUM_DIGITS);

  logic [CNT_W-1:0]      div_cnt;
  logic [SLOT_W-1:0]     slot;
  bcd_t                  shadow_digits [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic                  capture;
  logic [NUM_DIGITS-1:0] blank;
  logic                  higher_nz;
  logic [NUM_DIGITS-1:0] slot_onehot;
  seg_t                  cur_seg;
  logic                  lit;

  logic [NUM_DIGITS-1:0] an_reg;
  seg_t                  seg_reg;
  logic                  dp_reg;
  logic                  frame_start_reg;

  // Refresh divider and slot counter; free-running regardless of enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      slot    <= '0;
    end else if (div_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      div_cnt <= '0;
      slot    <= (slot == SLOT_W'(NUM_DIGITS - 1)) ? '0 : slot + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign capture = (div_cnt == '0) && (slot == '0);

  // Shadow digits load only at frame start so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) shadow_digits[i] <= '0;
      shadow_dp <= '0;
    end else if (capture) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        shadow_digits[i] <= bus.digits_in[BCD_W*i +: BCD_W];
      end
      shadow_dp <= bus.dp_in;
    end
  end

  // Frame pulse lands on the cycle after the shadow capture.
  always_ff @(posedge clk) begin
    if (rst) frame_start_reg <= 1'b0;
    else     frame_start_reg <= capture;
  end

  // Digit i blanks while it and every more significant digit are zero.
  always_comb begin
    higher_nz = 1'b0;
    blank     = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      higher_nz = higher_nz | (shadow_digits[i] != '0);
      blank[i]  = (LZ_BLANK != 0) && (i != 0) && !higher_nz;
    end
  end

  // Anode select and lit decision for the slot currently being scanned.
  always_comb begin
    slot_onehot       = '0;
    slot_onehot[slot] = 1'b1;
    lit = bus.enable && (div_cnt >= CNT_W'(DEAD_CYCLES)) && !blank[slot];
  end

  bcd_to_7seg u_dec (
    .bcd (shadow_digits[slot]),
    .seg (cur_seg)
  );

  // Registered display drive; dark unless the slot is lit.
  always_ff @(posedge clk) begin
    if (rst || !lit) begin
      an_reg  <= '1;
      seg_reg <= SEG_BLANK;
      dp_reg  <= 1'b1;
    end else begin
      an_reg  <= ~slot_onehot;
      seg_reg <= cur_seg;
      dp_reg  <= ~shadow_dp[slot];
    end
  end

  assign bus.an          = an_reg;
  assign bus.seg         = seg_reg;
  assign bus.dp          = dp_reg;
  assign bus.frame_start = frame_start_reg;

endmodule
